irq_ctrl: RTL

Interrupt controller sitting directly upstream of the CPU's IRQ input. It synchronizes up to N_SRC asynchronous external request lines and detects their rising edges. Captured requests are held as pending, and the highest-priority enabled one is presented to the CPU as a level `INT_irq` plus a vector address `INT_Vector`. It tracks the acknowledge / end-of-interrupt handshake so only one interrupt is in service at a time (no nesting).

---
 rtl/irq_ctrl_pkg.sv | 18 +
 rtl/irq_ctrl_if.sv | 27 ++
 rtl/irq_ctrl_sync.sv | 31 +++
 rtl/irq_ctrl.sv | 119 +++++++++++
 4 files changed

// File: rtl/irq_ctrl_pkg.sv
// Shared types and defaults for the interrupt controller.
package irq_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQ     = 2'd1,
        SERVICE = 2'd2
    } irq_state_e;

    localparam logic [31:0] VEC_BASE_DEFAULT   = 32'h0000_0020;
    localparam logic [31:0] VEC_STRIDE_DEFAULT = 32'd4;

    // Width of a source index; never narrower than one bit.
    function automatic int unsigned id_width(input int unsigned n_src);
        return (n_src <= 2) ? 1 : $clog2(n_src);
    endfunction

endpackage

// File: rtl/irq_ctrl_if.sv
// CPU-side handshake of the interrupt controller.
interface irq_ctrl_if
    import irq_pkg::*;
#(
    parameter int unsigned N_SRC = 4
);
    localparam int unsigned ID_W = id_width(N_SRC);

    logic            I_bit;
    logic            INT_ack;
    logic            INT_eoi;
    logic            INT_irq;
    logic            In_service;
    logic [31:0]     INT_Vector;
    logic [ID_W-1:0] INT_id;

    modport master (
        input  I_bit, INT_ack, INT_eoi,
        output INT_irq, In_service, INT_Vector, INT_id
    );

    modport slave (
        output I_bit, INT_ack, INT_eoi,
        input  INT_irq, In_service, INT_Vector, INT_id
    );

endinterface

// File: rtl/irq_ctrl_sync.sv
// Two-flop synchronizer and rising-edge detector for one request line.
module irq_sync (
    input  logic clk,
    input  logic Rst,
    input  logic d,
    output logic rise
);
    logic s1_q, s2_q, prev_q;
    logic s1_d, s2_d, prev_d;

    always_comb begin
        s1_d   = d;
        s2_d   = s1_q;
        prev_d = s2_q;
    end

    always_ff @(posedge clk or negedge Rst) begin
        if (!Rst) begin
            s1_q   <= 1'b0;
            s2_q   <= 1'b0;
            prev_q <= 1'b0;
        end else begin
            s1_q   <= s1_d;
            s2_q   <= s2_d;
            prev_q <= prev_d;
        end
    end

    assign rise = s2_q & ~prev_q;

endmodule

// File: rtl/irq_ctrl.sv
// Interrupt controller: edge capture, pending register, fixed priority and
// a single-level ack/eoi handshake towards the CPU.
module irq_ctrl
    import irq_pkg::*;
#(
    parameter int unsigned N_SRC      = 4,
    parameter logic [31:0] VEC_BASE   = VEC_BASE_DEFAULT,
    parameter logic [31:0] VEC_STRIDE = VEC_STRIDE_DEFAULT
) (
    input  logic             clk,
    input  logic             Rst,
    input  logic [N_SRC-1:0] EX_irq,
    input  logic [N_SRC-1:0] irq_en,
    output logic [N_SRC-1:0] Pending,
    irq_ctrl_if.master       cpu
);
    localparam int unsigned ID_W = id_width(N_SRC);

    irq_state_e       state_q, state_d;
    logic [N_SRC-1:0] pend_q, pend_d;
    logic [ID_W-1:0]  id_q, id_d;
    logic             irq_q, irq_d;
    logic             svc_q, svc_d;

    logic [N_SRC-1:0] rise;
    logic [N_SRC-1:0] clr;
    logic [N_SRC-1:0] id_mask;
    logic             cur_en;
    logic             cand_vld;
    logic [ID_W-1:0]  cand_id;

    for (genvar g = 0; g < N_SRC; g++) begin : g_sync
        irq_sync u_sync (
            .clk  (clk),
            .Rst  (Rst),
            .d    (EX_irq[g]),
            .rise (rise[g])
        );
    end

    // Scan from the top down so the lowest pending+enabled index wins.
    always_comb begin
        cand_vld = 1'b0;
        cand_id  = '0;
        for (int unsigned i = N_SRC; i > 0; i--) begin
            if (pend_q[i-1] && irq_en[i-1]) begin
                cand_vld = 1'b1;
                cand_id  = ID_W'(i - 1);
            end
        end
    end

    // Decode the latched id by comparison so non-power-of-two N_SRC stays in range.
    always_comb begin
        id_mask = '0;
        cur_en  = 1'b0;
        for (int unsigned i = 0; i < N_SRC; i++) begin
            if (id_q == ID_W'(i)) begin
                id_mask[i] = 1'b1;
                cur_en     = irq_en[i];
            end
        end
    end

    always_comb begin
        state_d = state_q;
        id_d    = id_q;
        clr     = '0;
        case (state_q)
            IDLE: begin
                if (cand_vld && !cpu.I_bit) begin
                    id_d    = cand_id;
                    state_d = REQ;
                end
            end
            REQ: begin
                if (cpu.INT_ack) begin
                    clr     = id_mask;
                    state_d = SERVICE;
                end else if (!cur_en || cpu.I_bit) begin
                    state_d = IDLE;
                end
            end
            SERVICE: begin
                if (cpu.INT_eoi) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        // A new edge on the line being acknowledged must survive the clear.
        pend_d = (pend_q & ~clr) | rise;
        irq_d  = (state_d == REQ);
        svc_d  = (state_d == SERVICE);
    end

    always_ff @(posedge clk or negedge Rst) begin
        if (!Rst) begin
            state_q <= IDLE;
            pend_q  <= '0;
            id_q    <= '0;
            irq_q   <= 1'b0;
            svc_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pend_q  <= pend_d;
            id_q    <= id_d;
            irq_q   <= irq_d;
            svc_q   <= svc_d;
        end
    end

    assign Pending        = pend_q;
    assign cpu.INT_irq    = irq_q;
    assign cpu.In_service = svc_q;
    assign cpu.INT_id     = id_q;
    assign cpu.INT_Vector = VEC_BASE + (32'(id_q) * VEC_STRIDE);

endmodule
